// File: rtl/upd1771c_pkt_seq.sv
// upd1771c_pkt_seq: host-side packet sequencer for the uPD1771C sound APU.
// Buffers {last,byte} command entries in a FIFO, then writes them to the APU
// parallel port (PA data, PB7 nCS, PB6 nWR). The first byte of a packet is
// written without looking at DSB. Every later byte waits for DSB high, strobes,
// and then waits for DSB low.
// Optional feature: define UPD1771C_PKT_TIMEOUT_EN to bound both DSB waits.
// A bounded wait that expires sets the sticky ERR flag and flushes the rest of
// the packet. When the macro is undefined, ERR is tied low and ERR_CLR has no
// effect.
module upd1771c_pkt_seq #(
  parameter int FIFO_DEPTH  = 16,
  parameter int STROBE_CYC  = 8,
  parameter int DSB_TIMEOUT = 4096
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       WR_EN,
  input  logic [7:0] WR_DATA,
  input  logic       WR_LAST,
  output logic       WR_FULL,
  output logic       BUSY,
  output logic       ERR,
  input  logic       ERR_CLR,
  output logic [7:0] APU_DIN,
  output logic       APU_NCS,
  output logic       APU_NWR,
  input  logic       APU_DSB
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(STROBE_CYC);
  localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYC - 1);
  localparam logic [AW:0]   DEPTH_CNT   = (AW+1)'(FIFO_DEPTH);

`ifdef UPD1771C_PKT_TIMEOUT_EN
  localparam logic [12:0] TO_LAST = 13'(DSB_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, STROBE, HOLD, WAIT_HI, WAIT_LO, FLUSH
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, STROBE, HOLD, WAIT_HI, WAIT_LO
  } state_t;
`endif

  // FIFO storage and bookkeeping
  logic [8:0]    fifoMem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [AW:0]   count_q, count_d;
  logic          full_q;
  logic          push, pop, fifoEmpty;
  logic [7:0]    headData;
  logic          headLast;

  // Sequencer registers
  state_t        state_q;
  logic [7:0]    din_q;
  logic          ncs_q, nwr_q;
  logic          last_q, first_q;
  logic [CW-1:0] strobeCnt_q;
  logic          err_q;
`ifdef UPD1771C_PKT_TIMEOUT_EN
  logic [12:0]   toCnt_q;
`endif

  assign fifoEmpty = (count_q == '0);
  assign headData  = fifoMem[rdPtr_q][7:0];
  assign headLast  = fifoMem[rdPtr_q][8];
  // A push is refused whenever the registered full flag is set. This holds even
  // if a pop frees a slot in the same cycle.
  assign push      = WR_EN && !full_q;

  // The sequencer takes the FIFO head only in the states that consume a byte.
  always_comb begin
    pop = 1'b0;
    case (state_q)
      IDLE:    pop = !fifoEmpty;
      WAIT_HI: pop = APU_DSB && !fifoEmpty;
`ifdef UPD1771C_PKT_TIMEOUT_EN
      FLUSH:   pop = !fifoEmpty;
`endif
      default: pop = 1'b0;
    endcase
  end

  // Next occupancy count from this cycle's push and pop.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // The FIFO data array has no reset. Only the pointers and count decide what is valid.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifoMem[wrPtr_q] <= {WR_LAST, WR_DATA};
    end
  end

  // FIFO pointers, count and registered full flag.
  always_ff @(posedge CLK) begin
    if (RES) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == DEPTH_CNT);
    end
  end

  // Sequencer FSM. It owns the registered APU port outputs and the sticky error flag.
  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q     <= IDLE;
      din_q       <= 8'h00;
      ncs_q       <= 1'b1;
      nwr_q       <= 1'b1;
      last_q      <= 1'b0;
      first_q     <= 1'b0;
      strobeCnt_q <= '0;
      err_q       <= 1'b0;
`ifdef UPD1771C_PKT_TIMEOUT_EN
      toCnt_q     <= '0;
`endif
    end else begin
`ifdef UPD1771C_PKT_TIMEOUT_EN
      if (ERR_CLR) err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (!fifoEmpty) begin
            din_q       <= headData;
            last_q      <= headLast;
            first_q     <= 1'b1;
            ncs_q       <= 1'b0;
            nwr_q       <= 1'b0;
            strobeCnt_q <= '0;
            state_q     <= STROBE;
          end
        end
        STROBE: begin
          if (strobeCnt_q == STROBE_LAST) begin
            ncs_q   <= 1'b1;
            nwr_q   <= 1'b1;
            state_q <= HOLD;
          end else begin
            strobeCnt_q <= strobeCnt_q + 1'b1;
          end
        end
        HOLD: begin
`ifdef UPD1771C_PKT_TIMEOUT_EN
          toCnt_q <= '0;
`endif
          if (!first_q) begin
            state_q <= WAIT_LO;
          end else if (last_q) begin
            state_q <= IDLE;
          end else begin
            state_q <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (APU_DSB && !fifoEmpty) begin
            din_q       <= headData;
            last_q      <= headLast;
            first_q     <= 1'b0;
            ncs_q       <= 1'b0;
            nwr_q       <= 1'b0;
            strobeCnt_q <= '0;
            state_q     <= STROBE;
          end
`ifdef UPD1771C_PKT_TIMEOUT_EN
          else if (!fifoEmpty) begin
            if (toCnt_q == TO_LAST) begin
              err_q   <= 1'b1;
              state_q <= FLUSH;
            end else begin
              toCnt_q <= toCnt_q + 13'd1;
            end
          end
`endif
        end
        WAIT_LO: begin
          if (!APU_DSB) begin
`ifdef UPD1771C_PKT_TIMEOUT_EN
            toCnt_q <= '0;
`endif
            state_q <= last_q ? IDLE : WAIT_HI;
          end
`ifdef UPD1771C_PKT_TIMEOUT_EN
          else if (toCnt_q == TO_LAST) begin
            err_q   <= 1'b1;
            state_q <= last_q ? IDLE : FLUSH;
          end else begin
            toCnt_q <= toCnt_q + 13'd1;
          end
`endif
        end
`ifdef UPD1771C_PKT_TIMEOUT_EN
        FLUSH: begin
          if (!fifoEmpty && headLast) begin
            state_q <= IDLE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

`ifndef UPD1771C_PKT_TIMEOUT_EN
  logic [13:0] unusedCfg;
  assign unusedCfg = {ERR_CLR, 13'(DSB_TIMEOUT)};
`endif

  assign WR_FULL = full_q;
  assign BUSY    = (state_q != IDLE) || !fifoEmpty;
  assign ERR     = err_q;
  assign APU_DIN = din_q;
  assign APU_NCS = ncs_q;
  assign APU_NWR = nwr_q;

endmodule

// File: tb/tb_upd1771c_pkt_seq.sv
// tb_upd1771c_pkt_seq: scoreboard bench for upd1771c_pkt_seq.
// Every accepted byte queues its expected strobe: the data, the number of
// low cycles, and the DIN value that must follow the strobe. A monitor checks
// every nCS strobe against that queue. A DSB model reproduces the APU
// handshake. It raises DSB 20 cycles after a strobe starts and drops it 5
// cycles into the next strobe.
// The timeout scenario is compiled only when UPD1771C_PKT_TIMEOUT_EN is defined.
module tb_upd1771c_pkt_seq;

  logic       CLK = 1'b0;
  logic       RES;
  logic       WR_EN;
  logic [7:0] WR_DATA;
  logic       WR_LAST;
  logic       WR_FULL;
  logic       BUSY;
  logic       ERR;
  logic       ERR_CLR;
  logic [7:0] APU_DIN;
  logic       APU_NCS;
  logic       APU_NWR;
  logic       APU_DSB;

  logic dsbAuto  = 1'b1;
  logic dsbForce = 1'b0;
  logic dsbModel = 1'b0;

  typedef struct {
    logic [7:0] data;
    int         width;
    logic [7:0] holdDin;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad = 0;
  int   strobeCount = 0;

  upd1771c_pkt_seq #(
    .FIFO_DEPTH (16),
    .STROBE_CYC (8),
    .DSB_TIMEOUT(4096)
  ) dut (
    .CLK     (CLK),
    .RES     (RES),
    .WR_EN   (WR_EN),
    .WR_DATA (WR_DATA),
    .WR_LAST (WR_LAST),
    .WR_FULL (WR_FULL),
    .BUSY    (BUSY),
    .ERR     (ERR),
    .ERR_CLR (ERR_CLR),
    .APU_DIN (APU_DIN),
    .APU_NCS (APU_NCS),
    .APU_NWR (APU_NWR),
    .APU_DSB (APU_DSB)
  );

  assign APU_DSB = dsbAuto ? dsbModel : dsbForce;

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Push one byte; if it should be accepted, queue the strobe it must produce.
  task automatic applyStimulus(input logic [7:0] d, input logic l, input bit accept,
                               input int width, input logic [7:0] holdDin);
    exp_t e;
    @(negedge CLK);
    WR_EN   = 1'b1;
    WR_DATA = d;
    WR_LAST = l;
    if (accept) begin
      e.data    = d;
      e.width   = width;
      e.holdDin = holdDin;
      expQ.push_back(e);
    end
    @(negedge CLK);
    WR_EN = 1'b0;
  endtask

  task automatic waitNcs(input logic level, input int limit, input string name);
    int n = 0;
    while (APU_NCS !== level && n < limit) begin
      @(negedge CLK);
      n++;
    end
    checkOutput(name, 32'(APU_NCS), 32'(level));
  endtask

  task automatic waitIdle(input int limit, input string name);
    int n = 0;
    while (BUSY !== 1'b0 && n < limit) begin
      @(negedge CLK);
      n++;
    end
    checkOutput(name, 32'(BUSY), 32'd0);
  endtask

  // DSB model: DSB goes low 5 cycles into each strobe and high 20 cycles into it.
  int   since = -1;
  logic dsbPrevNcs = 1'b1;
  always @(negedge CLK) begin
    if (APU_NCS === 1'b0 && dsbPrevNcs) since = 0;
    else if (since >= 0) since++;
    if (since == 5)  dsbModel = 1'b0;
    if (since == 20) dsbModel = 1'b1;
    dsbPrevNcs = APU_NCS;
  end

  // Monitor: match each strobe against the scoreboard.
  logic       prevNcs = 1'b1;
  int         lowCnt = 0;
  int         curWidth = 0;
  logic [7:0] curHold = 8'h00;
  always @(negedge CLK) begin
    exp_t e;
    if (APU_NCS === 1'b0) begin
      if (prevNcs) begin
        strobeCount++;
        checkOutput("strobe_pending", 32'(expQ.size() > 0), 32'd1);
        if (expQ.size() > 0) begin
          e = expQ.pop_front();
          checkOutput("strobe_din", 32'(APU_DIN), 32'(e.data));
          curWidth = e.width;
          curHold  = e.holdDin;
        end else begin
          curWidth = 0;
          curHold  = 8'h00;
        end
        lowCnt = 1;
      end else begin
        lowCnt++;
      end
      checkOutput("nwr_low", 32'(APU_NWR), 32'd0);
    end else if (!prevNcs) begin
      checkOutput("strobe_width", 32'(lowCnt), 32'(curWidth));
      checkOutput("hold_din", 32'(APU_DIN), 32'(curHold));
      checkOutput("nwr_high", 32'(APU_NWR), 32'd1);
    end
    prevNcs = APU_NCS;
  end

  initial begin
    #2000000;
    bad++;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    RES     = 1'b1;
    WR_EN   = 1'b0;
    WR_DATA = 8'h00;
    WR_LAST = 1'b0;
    ERR_CLR = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("rst_ncs",  32'(APU_NCS), 32'd1);
    checkOutput("rst_nwr",  32'(APU_NWR), 32'd1);
    checkOutput("rst_din",  32'(APU_DIN), 32'h00);
    checkOutput("rst_full", 32'(WR_FULL), 32'd0);
    checkOutput("rst_busy", 32'(BUSY),    32'd0);
    checkOutput("rst_err",  32'(ERR),     32'd0);
    RES = 1'b0;

    // Four-byte packet paced by the DSB model.
    $display("[TB] packet 02 80 35 15");
    applyStimulus(8'h02, 1'b0, 1'b1, 8, 8'h02);
    applyStimulus(8'h80, 1'b0, 1'b1, 8, 8'h80);
    applyStimulus(8'h35, 1'b0, 1'b1, 8, 8'h35);
    applyStimulus(8'h15, 1'b1, 1'b1, 8, 8'h15);
    waitIdle(400, "t1_idle");
    checkOutput("t1_dsb_low_at_idle", 32'(APU_DSB), 32'd0);
    checkOutput("t1_drained", 32'(expQ.size()), 32'd0);
    repeat (30) @(negedge CLK);

    // A single-byte packet needs no DSB handshake.
    $display("[TB] single byte 00");
    applyStimulus(8'h00, 1'b1, 1'b1, 8, 8'h00);
    waitNcs(1'b0, 20, "t2_strobe_start");
    waitNcs(1'b1, 20, "t2_strobe_end");
    checkOutput("t2_busy_hold", 32'(BUSY), 32'd1);
    @(negedge CLK);
    checkOutput("t2_busy_after_hold", 32'(BUSY), 32'd0);
    repeat (5) @(negedge CLK);

    // Fill the FIFO while DSB is held low. The first byte strobes and then stalls in WAIT_HI.
    $display("[TB] fifo fill");
    dsbAuto  = 1'b0;
    dsbForce = 1'b0;
    base = strobeCount;
    applyStimulus(8'hA0, 1'b0, 1'b1, 8, 8'hA0);
    waitNcs(1'b0, 20, "t3_first_start");
    waitNcs(1'b1, 20, "t3_first_end");
    repeat (5) @(negedge CLK);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(8'h50 + 8'(i), (i == 15), 1'b1, 8, 8'h50 + 8'(i));
      if (i == 14) checkOutput("t3_not_full_15", 32'(WR_FULL), 32'd0);
      if (i == 15) checkOutput("t3_full_16", 32'(WR_FULL), 32'd1);
    end
    applyStimulus(8'hEE, 1'b1, 1'b0, 0, 8'h00);
    checkOutput("t3_full_after_drop", 32'(WR_FULL), 32'd1);
    checkOutput("t3_one_strobe", 32'(strobeCount - base), 32'd1);
    dsbAuto = 1'b1;
    waitIdle(1500, "t3_drain_idle");
    checkOutput("t3_drained", 32'(expQ.size()), 32'd0);
    checkOutput("t3_full_clear", 32'(WR_FULL), 32'd0);
    repeat (30) @(negedge CLK);

    // A host gap mid-packet. The next byte strobes one cycle after it becomes visible.
    $display("[TB] mid-packet host stall");
    dsbAuto  = 1'b0;
    dsbForce = 1'b1;
    applyStimulus(8'h02, 1'b0, 1'b1, 8, 8'h02);
    waitNcs(1'b0, 20, "t4_first_start");
    waitNcs(1'b1, 20, "t4_first_end");
    repeat (100) @(negedge CLK);
    applyStimulus(8'h80, 1'b1, 1'b1, 8, 8'h80);
    checkOutput("t4_visible_cycle_ncs", 32'(APU_NCS), 32'd1);
    @(negedge CLK);
    checkOutput("t4_strobe_start", 32'(APU_NCS), 32'd0);
    waitNcs(1'b1, 20, "t4_second_end");
    repeat (10) @(negedge CLK);
    checkOutput("t4_busy_wait_lo", 32'(BUSY), 32'd1);
    dsbForce = 1'b0;
    waitIdle(10, "t4_idle");

`ifdef UPD1771C_PKT_TIMEOUT_EN
    // DSB stuck low: a timeout flushes the rest of the packet, and the next packet still runs.
    $display("[TB] dsb timeout");
    base = strobeCount;
    applyStimulus(8'h02, 1'b0, 1'b1, 8, 8'h02);
    applyStimulus(8'h80, 1'b0, 1'b0, 0, 8'h00);
    applyStimulus(8'h35, 1'b0, 1'b0, 0, 8'h00);
    applyStimulus(8'h15, 1'b1, 1'b0, 0, 8'h00);
    applyStimulus(8'h00, 1'b1, 1'b1, 8, 8'h00);
    waitNcs(1'b1, 20, "t5_first_end");
    repeat (4000) @(negedge CLK);
    checkOutput("t5_err_early", 32'(ERR), 32'd0);
    begin
      int n = 0;
      while (ERR !== 1'b1 && n < 300) begin
        @(negedge CLK);
        n++;
      end
    end
    checkOutput("t5_err_set", 32'(ERR), 32'd1);
    waitIdle(200, "t5_idle");
    checkOutput("t5_strobes", 32'(strobeCount - base), 32'd2);
    checkOutput("t5_err_sticky", 32'(ERR), 32'd1);
    @(negedge CLK);
    ERR_CLR = 1'b1;
    @(negedge CLK);
    ERR_CLR = 1'b0;
    checkOutput("t5_err_clr", 32'(ERR), 32'd0);
`endif

    // Reset in cycle 4 of a strobe releases the port and drops the queued byte.
    $display("[TB] reset mid-strobe");
    dsbAuto  = 1'b0;
    dsbForce = 1'b0;
    base = strobeCount;
    applyStimulus(8'h02, 1'b0, 1'b1, 4, 8'h00);
    waitNcs(1'b0, 20, "t6_strobe_start");
    applyStimulus(8'h80, 1'b1, 1'b0, 0, 8'h00);
    @(negedge CLK);
    RES = 1'b1;
    @(negedge CLK);
    RES = 1'b0;
    checkOutput("t6_ncs", 32'(APU_NCS), 32'd1);
    checkOutput("t6_nwr", 32'(APU_NWR), 32'd1);
    checkOutput("t6_din", 32'(APU_DIN), 32'h00);
    checkOutput("t6_busy", 32'(BUSY), 32'd0);
    repeat (50) @(negedge CLK);
    checkOutput("t6_no_more_strobes", 32'(strobeCount - base), 32'd1);
    checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
